// File: rtl/button_step_pkg.sv
// Shared types and default timing constants for the push-button step generator.
package button_step_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } state_e;

  localparam int unsigned DefDbCycles     = 16;
  localparam int unsigned DefCntW         = 16;
  localparam int unsigned DefRepeatDelay  = 64;
  localparam int unsigned DefRepeatPeriod = 16;

endpackage

// File: rtl/button_step_gen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_step_gen.sv
// Debounced push-button to single-cycle step pulse generator.
// Define BUTTON_STEP_AUTO_REPEAT_EN to add hold-to-repeat stepping.
module button_step_gen
  import button_step_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DefDbCycles,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic step,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  if (DB_CYCLES < 2 || 64'(DB_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_db_cycles
    $error("DB_CYCLES must be in [2, 2**CNT_W-1]");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
      64'(REPEAT_DELAY) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_repeat
    $error("REPEAT_PERIOD must be in [1, REPEAT_DELAY] and REPEAT_DELAY fit CNT_W");
  end

  logic sync;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d, db_cnt_inc;
  logic             step_q, step_d;
  logic             level_q, level_d;
  logic             press_accept;
  logic             rpt_fire;

  assign db_cnt_inc = (db_cnt_q == CntMax) ? db_cnt_q : db_cnt_q + 1'b1;

  // The incremented count is compared so HELD is reached after DB_CYCLES stable samples.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    case (state_q)
      StIdle: begin
        if (sync) begin
          state_d  = StPressWait;
          db_cnt_d = '0;
        end
      end
      StPressWait: begin
        if (!sync) begin
          state_d  = StIdle;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_inc;
          if (db_cnt_inc == DbLast) state_d = StHeld;
        end
      end
      StHeld: begin
        if (!sync) begin
          state_d  = StReleaseWait;
          db_cnt_d = '0;
        end
      end
      StReleaseWait: begin
        if (sync) begin
          state_d = StHeld;
        end else begin
          db_cnt_d = db_cnt_inc;
          if (db_cnt_inc == DbLast) state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        db_cnt_d = '0;
      end
    endcase
  end

  assign press_accept = (state_q == StPressWait) && (state_d == StHeld);

`ifdef BUTTON_STEP_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RptLast   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RptReload = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] rpt_q, rpt_d;

  // Counts only across cycles that stay HELD, so a release glitch pauses the cadence.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (state_d == StIdle || press_accept) begin
      rpt_d = '0;
    end else if (state_q == StHeld && state_d == StHeld) begin
      if (rpt_q == RptLast) begin
        rpt_fire = 1'b1;
        rpt_d    = RptReload;
      end else if (rpt_q != CntMax) begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign step_d  = enable && !step_q && (press_accept || rpt_fire);
  assign level_d = (state_d == StHeld) || (state_d == StReleaseWait);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      db_cnt_q <= '0;
      step_q   <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      step_q   <= step_d;
      level_q  <= level_d;
    end
  end

  assign step      = step_q;
  assign btn_level = level_q;

endmodule

// File: doc/button_step_gen.md
BUTTON_STEP_GEN -- requirements
Module: button_step_gen

Interface
REQ-001 Parameter DB_CYCLES, default 16: cycles the synchronized input must be stable before a level change is accepted; SHALL be >= 2 and <= 2**CNT_W-1.
REQ-002 Parameter CNT_W, default 16: width of the debounce and repeat counters.
REQ-003 Parameter REPEAT_DELAY, default 64: held cycles before the first auto-repeat step.
REQ-004 Parameter REPEAT_PERIOD, default 16: cycles between subsequent auto-repeat steps.
REQ-005 Port clk, input, 1: single clock for all state; rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port btn_in, input, 1: raw, asynchronous push-button level, active-high.
REQ-008 Port enable, input, 1: step gate; when 0, step SHALL be suppressed while debouncing continues.
REQ-009 Port step, output, 1: registered single-cycle pulse; drives the downstream counter enable.
REQ-010 Port btn_level, output, 1: registered debounced button level.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer; only its output (sync) is used.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE: sync=1 -> PRESS_WAIT, debounce counter cleared to 0.
REQ-014 PRESS_WAIT: sync=0 -> IDLE; otherwise counter increments, and when counter==DB_CYCLES-1 with sync=1 -> HELD.
REQ-015 HELD: sync=0 -> RELEASE_WAIT, counter cleared.
REQ-016 RELEASE_WAIT: sync=1 -> HELD with no new step; otherwise counter increments, and at DB_CYCLES-1 -> IDLE.
REQ-017 btn_level SHALL be 1 exactly while the state is HELD or RELEASE_WAIT.
REQ-018 step SHALL be 1 for exactly one cycle, the first cycle the state register holds HELD after PRESS_WAIT, if enable=1 in the preceding cycle.
REQ-019 Latency from a clean btn_in rise to step/btn_level: DB_CYCLES+2 rising edges.
REQ-020 Bounce shorter than DB_CYCLES cycles SHALL produce no step and no btn_level change.
REQ-021 Counters SHALL saturate and never wrap; no step is ever generated on counter wrap-around.
REQ-022 step SHALL never be high on two consecutive cycles.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, counters 0, synchronizer flops 0, step=0, btn_level=0.
REQ-024 Reset mid-operation SHALL abandon any pending step; a button still held at reset release requires a full debounce and then yields one step.

Configuration
REQ-025 Macro BUTTON_STEP_AUTO_REPEAT_EN defined: in HELD, a repeat counter SHALL start at entry and emit step at REPEAT_DELAY cycles after the initial step, then every REPEAT_PERIOD cycles, gated by enable.
REQ-026 The repeat counter SHALL pause in RELEASE_WAIT and clear on entry to IDLE.
REQ-027 Macro undefined: exactly one step per accepted press, with no repeat counter logic present.

Structure
REQ-028 Package button_step_pkg SHALL hold the FSM state typedef (2-bit enum) and the default DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
REQ-029 The synchronizer SHALL be sub-module sync_2ff (clk, reset, d, q), reset value 0.

Verification (DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-030 Clean press: btn_in 0->1 held 20 cycles -> one step 6 edges after the rise and btn_level=1; with the macro undefined, no further step.
REQ-031 Bounce: three 1-cycle-high pulses separated by 1 low cycle -> step never asserted, btn_level stays 0, FSM returns to IDLE.
REQ-032 Release glitch: while HELD, btn_in low 2 cycles then high -> btn_level stays 1 and no second step.
REQ-033 Auto-repeat (macro defined): hold 30 cycles with first step at cycle t -> steps at t, t+8, t+11, t+14, ...; none after release.
REQ-034 Reset mid-PRESS_WAIT: reset=0 asynchronously -> step and btn_level 0 before the next edge; release with btn held -> step 6 edges later.
REQ-035 enable=0 throughout a clean press -> no step, btn_level still rises after 6 edges.
